// File: rtl/seg_scan_ctrl.sv
// Scan controller that time-shares one 3-bit seven-segment decoder across NDIG digits,
// with a double-buffered digit store swapped only at frame boundaries.
module seg_scan_ctrl #(
    parameter int NDIG  = 8,
    parameter int DIV   = 1000,
    parameter int BLANK = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [2:0]      wr_idx,
    input  logic [2:0]      wr_val,
    input  logic            wr_on,
    input  logic            commit,
    output logic            commit_pend,
    output logic            frame_start,
    output logic [2:0]      dec_b,
    output logic            dec_en,
    output logic [NDIG-1:0] dig_sel
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW = $clog2(NDIG);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(NDIG - 1);

    typedef enum logic {PH_BLANK, PH_SHOW} phase_t;

    logic            run_q, run_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   slot_q, slot_d;
    phase_t          phase_q, phase_d;
    logic [2:0]      stg_val_q [NDIG];
    logic [2:0]      stg_val_d [NDIG];
    logic            stg_on_q  [NDIG];
    logic            stg_on_d  [NDIG];
    logic [2:0]      act_val_q [NDIG];
    logic [2:0]      act_val_d [NDIG];
    logic            act_on_q  [NDIG];
    logic            act_on_d  [NDIG];
    logic            commit_pend_q, commit_pend_d;
    logic            frame_start_q, frame_start_d;
    logic [2:0]      dec_b_q, dec_b_d;
    logic            dec_en_q, dec_en_d;
    logic [NDIG-1:0] dig_sel_q, dig_sel_d;
    logic            boundary;
    logic            show_d;

    // run_q holds the counters at zero for one edge after reset so that the
    // first visible cycle is (slot 0, cnt 0) with frame_start raised.
    always_comb begin
        run_d    = 1'b1;
        cnt_d    = cnt_q;
        slot_d   = slot_q;
        phase_d  = phase_q;
        boundary = run_q && (slot_q == SLOT_LAST) && (cnt_q == CNT_LAST);
        if (run_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                phase_d = PH_BLANK;
                slot_d  = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BLANK_LAST) begin
                    phase_d = PH_SHOW;
                end
            end
        end
    end

    // Active loads the pre-write staging contents, so a same-cycle write waits for the next commit.
    always_comb begin
        for (int i = 0; i < NDIG; i++) begin
            stg_val_d[i] = stg_val_q[i];
            stg_on_d[i]  = stg_on_q[i];
            act_val_d[i] = (boundary && (commit_pend_q || commit)) ? stg_val_q[i] : act_val_q[i];
            act_on_d[i]  = (boundary && (commit_pend_q || commit)) ? stg_on_q[i]  : act_on_q[i];
        end
        if (wr_en && (int'(wr_idx) < NDIG)) begin
            stg_val_d[wr_idx[SW-1:0]] = wr_val;
            stg_on_d[wr_idx[SW-1:0]]  = wr_on;
        end
        commit_pend_d = boundary ? 1'b0 : (commit_pend_q || commit);
    end

    assign show_d = (phase_d == PH_SHOW);

    always_comb begin
        frame_start_d = (cnt_d == '0) && (slot_d == '0);
        dec_b_d       = show_d ? act_val_d[slot_d] : 3'd0;
        dec_en_d      = show_d && act_on_d[slot_d];
    end

    for (genvar gi = 0; gi < NDIG; gi++) begin : g_sel
        assign dig_sel_d[gi] = !(show_d && (slot_d == SW'(gi)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q         <= 1'b0;
            cnt_q         <= '0;
            slot_q        <= '0;
            phase_q       <= PH_BLANK;
            commit_pend_q <= 1'b0;
            frame_start_q <= 1'b0;
            dec_b_q       <= 3'd0;
            dec_en_q      <= 1'b0;
            dig_sel_q     <= '1;
            for (int i = 0; i < NDIG; i++) begin
                stg_val_q[i] <= 3'd0;
                stg_on_q[i]  <= 1'b0;
                act_val_q[i] <= 3'd0;
                act_on_q[i]  <= 1'b0;
            end
        end else begin
            run_q         <= run_d;
            cnt_q         <= cnt_d;
            slot_q        <= slot_d;
            phase_q       <= phase_d;
            commit_pend_q <= commit_pend_d;
            frame_start_q <= frame_start_d;
            dec_b_q       <= dec_b_d;
            dec_en_q      <= dec_en_d;
            dig_sel_q     <= dig_sel_d;
            for (int i = 0; i < NDIG; i++) begin
                stg_val_q[i] <= stg_val_d[i];
                stg_on_q[i]  <= stg_on_d[i];
                act_val_q[i] <= act_val_d[i];
                act_on_q[i]  <= act_on_d[i];
            end
        end
    end

    assign commit_pend = commit_pend_q;
    assign frame_start = frame_start_q;
    assign dec_b       = dec_b_q;
    assign dec_en      = dec_en_q;
    assign dig_sel     = dig_sel_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl: a frame-arithmetic reference model predicts every
// output on every cycle, with directed boundary-commit and mid-slot reset scenarios.
module tb_seg_scan_ctrl;
    localparam int NDIG  = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = NDIG * DIV;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wr_en = 1'b0;
    logic [2:0]      wr_idx = 3'd0;
    logic [2:0]      wr_val = 3'd0;
    logic            wr_on = 1'b0;
    logic            commit = 1'b0;
    logic            commit_pend;
    logic            frame_start;
    logic [2:0]      dec_b;
    logic            dec_en;
    logic [NDIG-1:0] dig_sel;

    seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .BLANK(BLANK)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .wr_val      (wr_val),
        .wr_on       (wr_on),
        .commit      (commit),
        .commit_pend (commit_pend),
        .frame_start (frame_start),
        .dec_b       (dec_b),
        .dec_en      (dec_en),
        .dig_sel     (dig_sel)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int k;
    int m_stg_val [NDIG];
    int m_stg_on  [NDIG];
    int m_act_val [NDIG];
    int m_act_on  [NDIG];
    int m_pend;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at k=%0d: got %0h expected %0h", tag, k, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NDIG; i++) begin
            m_stg_val[i] = 0;
            m_stg_on[i]  = 0;
            m_act_val[i] = 0;
            m_act_on[i]  = 0;
        end
        m_pend = 0;
    endtask

    // Expected outputs follow purely from the cycle number since the frame began.
    task automatic check_outputs();
        int c = k % DIV;
        int s = (k / DIV) % NDIG;
        logic [NDIG-1:0] e_sel;
        int e_b;
        int e_en;
        if (c < BLANK) begin
            e_sel = '1;
            e_b   = 0;
            e_en  = 0;
        end else begin
            e_sel = ~(NDIG'(1) << s);
            e_b   = m_act_val[s];
            e_en  = m_act_on[s];
        end
        chk("dig_sel", 32'(dig_sel), 32'(e_sel));
        chk("dec_b", 32'(dec_b), 32'(e_b));
        chk("dec_en", 32'(dec_en), 32'(e_en));
        chk("frame_start", 32'(frame_start), ((k % FRAME) == 0) ? 32'd1 : 32'd0);
        chk("commit_pend", 32'(commit_pend), 32'(m_pend));
    endtask

    task automatic step(input bit do_wr, input int idx, input int val, input bit on, input bit do_cmt);
        bit boundary = ((k % FRAME) == FRAME - 1);
        wr_en  = do_wr;
        wr_idx = 3'(idx);
        wr_val = 3'(val);
        wr_on  = on;
        commit = do_cmt;
        if (do_wr || do_cmt)
            $display("k=%0d wr=%0d idx=%0d val=%0d on=%0d commit=%0d boundary=%0d",
                     k, do_wr, idx, val, on, do_cmt, boundary);
        if (boundary && (m_pend != 0 || do_cmt)) begin
            for (int i = 0; i < NDIG; i++) begin
                m_act_val[i] = m_stg_val[i];
                m_act_on[i]  = m_stg_on[i];
            end
        end
        if (boundary) m_pend = 0;
        else if (do_cmt) m_pend = 1;
        if (do_wr && idx < NDIG) begin
            m_stg_val[idx] = val;
            m_stg_on[idx]  = on;
        end
        @(posedge clk);
        k++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            bit at_b = ((k % FRAME) == FRAME - 1);
            bit w    = ($urandom_range(0, 5) == 0) || (at_b && $urandom_range(0, 1) == 1);
            bit cm   = ($urandom_range(0, 39) == 0) || (at_b && $urandom_range(0, 1) == 1);
            step(w, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 $urandom_range(0, 3) != 0, cm);
        end
    endtask

    task automatic release_reset();
        wr_en  = 1'b0;
        commit = 1'b0;
        rst_n  = 1'b1;
        model_reset();
        k = 0;
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        k = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dig_sel", 32'(dig_sel), 32'hF);
        chk("rst_dec_en", 32'(dec_en), 32'd0);
        chk("rst_dec_b", 32'(dec_b), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_commit_pend", 32'(commit_pend), 32'd0);
        release_reset();

        // Write, commit, display
        step(1'b1, 0, 5, 1'b1, 1'b0);
        step(1'b1, 1, 2, 1'b1, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        idle(2 * FRAME);

        // No commit: staged digit stays invisible
        step(1'b1, 2, 7, 1'b1, 1'b0);
        idle(2 * FRAME);

        // Commit together with a write on the boundary cycle
        while ((k % FRAME) != FRAME - 1) step(1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 0, 3, 1'b1, 1'b1);
        idle(FRAME);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        idle(2 * FRAME);

        // Dark digit and out-of-range index
        step(1'b1, 2, 4, 1'b0, 1'b0);
        step(1'b1, 6, 7, 1'b1, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        idle(2 * FRAME);

        run_random(30 * FRAME);

        // Asynchronous reset in the middle of a SHOW interval with a commit pending
        step(1'b1, 3, 6, 1'b1, 1'b1);
        while ((k % DIV) != 5) step(1'b0, 0, 0, 1'b0, 1'b0);
        wr_en  = 1'b0;
        commit = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dig_sel", 32'(dig_sel), 32'hF);
        chk("arst_dec_en", 32'(dec_en), 32'd0);
        chk("arst_dec_b", 32'(dec_b), 32'd0);
        chk("arst_commit_pend", 32'(commit_pend), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        release_reset();
        idle(2 * FRAME);
        run_random(10 * FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
